// File: rtl/lwe_decrypt_pkg.sv
// Shared definitions for the streaming LWE decrypt engine.
//   state_t         : FSM states (IDLE, ACCUM, HOLD)
//   calc_vec_len    : VEC_LEN = DIMENSION + 1 (b term plus n a-terms)
//   calc_beats      : BEATS = ceil(VEC_LEN / PARALLEL)
//   calc_round_half : ROUND_HALF = Q / (2P), the rounding offset for decode
// Derived constants are functions because the dimensions are per-instance
// parameters of lwe_decrypt_stream.
package lwe_decrypt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int calc_vec_len(input int dimension);
        return dimension + 1;
    endfunction

    function automatic int calc_beats(input int vec_len, input int parallel);
        return (vec_len + parallel - 1) / parallel;
    endfunction

    function automatic int calc_round_half(input int q, input int p);
        return q / (2 * p);
    endfunction

endpackage

// File: rtl/lwe_decrypt_lane_mac.sv
// Combinational beat reduction for lwe_decrypt_stream.
// Multiplies each sk/ct lane pair mod Q, drops lanes whose mask bit is low
// (vector positions past VEC_LEN on the final beat), and sums mod Q.
// Ports:
//   sk_entry  : PARALLEL x CIPHERTEXT_WIDTH secret-key lanes, lane 0 lowest
//   ct_entry  : PARALLEL x CIPHERTEXT_WIDTH ciphertext lanes
//   lane_mask : 1 = lane carries a real vector element
//   beat_sum  : sum of masked products, wrapped to CIPHERTEXT_WIDTH bits
module lwe_decrypt_lane_mac #(
    parameter int PARALLEL         = 1,
    parameter int CIPHERTEXT_WIDTH = 10
) (
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] sk_entry,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ct_entry,
    input  logic [PARALLEL-1:0]                  lane_mask,
    output logic [CIPHERTEXT_WIDTH-1:0]          beat_sum
);

    always_comb begin
        logic [CIPHERTEXT_WIDTH-1:0] prod;
        beat_sum = '0;
        prod     = '0;
        for (int unsigned i = 0; i < PARALLEL; i++) begin
            // Product evaluated at CIPHERTEXT_WIDTH bits: truncation is mod Q.
            prod = sk_entry[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH]
                 * ct_entry[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
            if (lane_mask[i]) begin
                beat_sum = beat_sum + prod;
            end
        end
    end

endmodule

// File: rtl/lwe_decrypt_stream.sv
// Streaming LWE decryption engine.
// Accepts PARALLEL-wide sk/ct beats over a valid/ready handshake, accumulates
// the dot product mod Q over BEATS beats, decodes it to a plaintext and holds
// it on an output valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort, drops partial or held result
//   in_valid, in_ready  : input beat handshake (in_ready depends on state only)
//   sk_entry, ct_entry  : PARALLEL x CIPHERTEXT_WIDTH lanes, lane 0 lowest index
//   out_valid, out_ready: result handshake
//   result              : decoded plaintext, stable while held
//   busy                : high in ACCUM or HOLD
// Configuration macro: LWE_DECRYPT_ROUNDING_EN selects the rounded decode;
// without it the low PLAINTEXT_WIDTH bits of the accumulator are returned.
module lwe_decrypt_stream
    import lwe_decrypt_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 10,
    parameter int PARALLEL           = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] sk_entry,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ct_entry,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]           result,
    output logic                                 busy
);

    localparam int VEC_LEN = calc_vec_len(DIMENSION);
    localparam int BEATS   = calc_beats(VEC_LEN, PARALLEL);
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) ||
            CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) ||
            CIPHERTEXT_WIDTH <= PLAINTEXT_WIDTH ||
            PARALLEL < 1 || PARALLEL > VEC_LEN) begin : g_bad_cfg
            $error("lwe_decrypt_stream: inconsistent parameters");
        end
    endgenerate

    state_t                      state;
    logic [CIPHERTEXT_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            cnt;
    logic [PARALLEL-1:0]         lane_mask;
    logic [CIPHERTEXT_WIDTH-1:0] beat_sum;
    logic [CIPHERTEXT_WIDTH-1:0] acc_next;
    logic [PLAINTEXT_WIDTH-1:0]  decoded;
    logic                        last_beat;
    logic                        accept;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    // Lane i of beat cnt holds vector index cnt*PARALLEL+i; only the final
    // beat can carry indices past VEC_LEN.
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < PARALLEL; i++) begin
            lane_mask[i] = (int'(cnt) * PARALLEL + int'(i)) < VEC_LEN;
        end
    end

    lwe_decrypt_lane_mac #(
        .PARALLEL        (PARALLEL),
        .CIPHERTEXT_WIDTH(CIPHERTEXT_WIDTH)
    ) u_lane_mac (
        .sk_entry (sk_entry),
        .ct_entry (ct_entry),
        .lane_mask(lane_mask),
        .beat_sum (beat_sum)
    );

    // acc still holds the previous ciphertext while IDLE, so the first beat
    // loads rather than adds.
    assign acc_next = (state == IDLE) ? beat_sum : acc + beat_sum;

`ifdef LWE_DECRYPT_ROUNDING_EN
    localparam logic [CIPHERTEXT_WIDTH:0] ROUND_HALF =
        (CIPHERTEXT_WIDTH+1)'(calc_round_half(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));

    logic [CIPHERTEXT_WIDTH:0] rounded;

    // The carry bit weighs exactly P after the shift, so dropping it wraps
    // values near Q to 0.
    assign rounded = {1'b0, acc_next} + ROUND_HALF;
    assign decoded = PLAINTEXT_WIDTH'(rounded >> (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH));
`else
    assign decoded = acc_next[PLAINTEXT_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= acc_next;
                        if (BEATS == 1) begin
                            result <= decoded;
                            state  <= HOLD;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            result <= decoded;
                            cnt    <= '0;
                            state  <= HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// Self-checking bench for lwe_decrypt_stream with P=64, Q=1024, n=4,
// PARALLEL=2 (3 beats). Expected values follow LWE_DECRYPT_ROUNDING_EN.
module tb_lwe_decrypt_stream;

    localparam int P   = 64;
    localparam int PW  = 6;
    localparam int Q   = 1024;
    localparam int CW  = 10;
    localparam int DIM = 4;
    localparam int PAR = 2;
    localparam int VL  = DIM + 1;
    localparam int NB  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PAR*CW-1:0] sk_entry = '0;
    logic [PAR*CW-1:0] ct_entry = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     result;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int cur_sk[VL];
    int cur_ct[VL];
    int pad_sk;
    int pad_ct;

    typedef struct {
        int sk[VL];
        int ct[VL];
        int pad_sk;
        int pad_ct;
        int exp_round;
        int exp_plain;
    } vec_t;

    vec_t vecs[4];

    lwe_decrypt_stream #(
        .PLAINTEXT_MODULUS (P),
        .PLAINTEXT_WIDTH   (PW),
        .CIPHERTEXT_MODULUS(Q),
        .CIPHERTEXT_WIDTH  (CW),
        .DIMENSION         (DIM),
        .PARALLEL          (PAR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sk_entry (sk_entry),
        .ct_entry (ct_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain dot product mod Q over the VEC_LEN real entries.
    function automatic int model_result();
        int acc = 0;
        for (int i = 0; i < VL; i++) begin
            acc = (acc + (cur_sk[i] * cur_ct[i]) % Q) % Q;
        end
`ifdef LWE_DECRYPT_ROUNDING_EN
        return ((acc + Q / (2 * P)) / (Q / P)) % P;
`else
        return acc % P;
`endif
    endfunction

    function automatic int pick(input int e_round, input int e_plain);
`ifdef LWE_DECRYPT_ROUNDING_EN
        return e_plain * 0 + e_round;
`else
        return e_round * 0 + e_plain;
`endif
    endfunction

    task automatic drive_beat(input int b);
        logic [CW-1:0] s0, s1, c0, c1;
        int i0 = b * PAR;
        int i1 = b * PAR + 1;
        s0 = CW'((i0 < VL) ? cur_sk[i0] : pad_sk);
        c0 = CW'((i0 < VL) ? cur_ct[i0] : pad_ct);
        s1 = CW'((i1 < VL) ? cur_sk[i1] : pad_sk);
        c1 = CW'((i1 < VL) ? cur_ct[i1] : pad_ct);
        sk_entry = {s1, s0};
        ct_entry = {c1, c0};
    endtask

    // Called at a negedge; returns at the negedge after the last beat's posedge.
    task automatic send_beats(input int nbeats, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            int waited = 0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            while (!in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) check("in_ready_wait", 0, 1);
            drive_beat(b);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int delay, input int expected);
        check({tag, "_latency"}, int'(out_valid), 1);
        for (int d = 0; d < delay; d++) begin
            out_ready = 1'b0;
            check({tag, "_hold_result"}, int'(result), expected);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
            check({tag, "_hold_busy"}, int'(busy), 1);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
        end
        out_ready = 1'b1;
        check({tag, "_result"}, int'(result), expected);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, int'(out_valid), 0);
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < VL; i++) begin
            cur_sk[i] = vecs[k].sk[i];
            cur_ct[i] = vecs[k].ct[i];
        end
        pad_sk = vecs[k].pad_sk;
        pad_ct = vecs[k].pad_ct;
    endtask

    initial begin
        vecs[0] = '{sk: '{1, 2, 3, 4, 5}, ct: '{10, 20, 30, 40, 50},
                    pad_sk: 0, pad_ct: 0, exp_round: 34, exp_plain: 38};
        vecs[1] = '{sk: '{1, 2, 3, 4, 5}, ct: '{10, 20, 30, 40, 50},
                    pad_sk: 7, pad_ct: 9, exp_round: 34, exp_plain: 38};
        vecs[2] = '{sk: '{1, 0, 0, 0, 0}, ct: '{1020, 0, 0, 0, 0},
                    pad_sk: 0, pad_ct: 0, exp_round: 0, exp_plain: 60};
        vecs[3] = '{sk: '{1023, 1023, 1023, 1023, 1023}, ct: '{1023, 1023, 1023, 1023, 1023},
                    pad_sk: 1023, pad_ct: 1023, exp_round: 0, exp_plain: 5};

        repeat (3) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors, out_ready high at the result.
        for (int k = 0; k < 4; k++) begin
            load_vec(k);
            send_beats(NB, 1'b0);
            collect($sformatf("vec%0d", k), 0, pick(vecs[k].exp_round, vecs[k].exp_plain));
        end

        // Back-pressure: result held for 3 cycles, input beats refused.
        load_vec(0);
        send_beats(NB, 1'b0);
        load_vec(2);
        drive_beat(0);
        in_valid = 1'b1;
        collect("backpressure", 3, pick(34, 38));
        in_valid = 1'b0;
        send_beats(NB, 1'b0);
        collect("after_hold", 0, pick(0, 60));

        // clear after two beats: no result, then a clean ciphertext.
        load_vec(0);
        send_beats(2, 1'b0);
        check("clear_busy_before", int'(busy), 1);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            check("clear_no_valid", int'(out_valid), 0);
            @(negedge clk);
        end

        // Reset pulse in the middle of a beat.
        send_beats(1, 1'b0);
        drive_beat(1);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid_in_ready", int'(in_ready), 1);
        check("rst_mid_busy", int'(busy), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("rst_mid_no_valid", int'(out_valid), 0);
            @(negedge clk);
        end
        send_beats(NB, 1'b0);
        collect("post_abort", 0, pick(34, 38));

        // clear while out_ready is high in HOLD: result is dropped.
        send_beats(NB, 1'b0);
        check("clear_hold_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b0;
        check("clear_hold_dropped", int'(out_valid), 0);
        check("clear_hold_busy", int'(busy), 0);

        // Randomized ciphertexts with input gaps and output stalls.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < VL; i++) begin
                cur_sk[i] = int'($urandom_range(0, Q - 1));
                cur_ct[i] = int'($urandom_range(0, Q - 1));
            end
            pad_sk = int'($urandom_range(0, Q - 1));
            pad_ct = int'($urandom_range(0, Q - 1));
            send_beats(NB, 1'b1);
            collect($sformatf("rand%0d", r), int'($urandom_range(0, 2)), model_result());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
